// File: rtl/uart_tx_fifo_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_sched
//
// Bus-attached transmit scheduler for the uart_tx core. Software pushes bytes
// into a circular FIFO through the peripheral bus. A small FSM then hands
// them to uart_tx one frame at a time, so software never has to poll busy
// per byte.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   req_i          bus request
//   write_enable_i 1 = write, 0 = read
//   addr_i         byte offset within the peripheral
//   write_data_i   bus write data
//   read_data_o    registered bus read data (0 after any non-read cycle)
//   tx_data_o      byte presented to uart_tx; holds the last launched byte
//   tx_valid_o     one-cycle launch strobe to uart_tx
//   tx_busy_i      uart_tx busy
//   irq_o          level interrupt: queue drained and transmitter idle
//
// Register map:
//   0x00 W  push write_data_i[7:0]
//   0x04 R  status = {16'b0, level[7:0], 5'b0, ovf, full, empty}
//   0x08 RW ctrl   = {irq_en, en}
//   0x0C W  writing exactly 1 flushes the FIFO and clears ovf
// ---------------------------------------------------------------------------
module uart_tx_fifo_sched #(
    parameter int DEPTH    = 16,
    parameter int IDLE_GAP = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_busy_i,
    output logic        irq_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    // Last value of the gap counter before returning to IDLE; a zero gap
    // still spends exactly one cycle in GAP.
    localparam logic [7:0]    GAP_LAST = (IDLE_GAP == 0) ? 8'd0 : 8'(IDLE_GAP - 1);

    localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
    localparam logic [31:0] ADDR_FLUSH  = 32'h0000_000C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;
    logic          ctrl_en;
    logic          ctrl_irq_en;

    logic [1:0]    wait_cnt;
    logic [7:0]    gap_cnt;

    logic          bus_wr;
    logic          bus_rd;
    logic          push_req;
    logic          flush_req;
    logic          ctrl_wr;
    logic          push_ok;
    logic          pop_ok;
    logic          fifo_empty;
    logic          fifo_full;
    logic          launch;
    logic [8:0]    level_wide;
    logic [7:0]    level_field;
    logic [31:0]   rd_mux;

    // Bus decode. A push and a flush cannot arrive together on this bus,
    // but flush is still given priority so the FIFO rules stay explicit.
    assign bus_wr    = req_i & write_enable_i;
    assign bus_rd    = req_i & ~write_enable_i;
    assign push_req  = bus_wr && (addr_i == ADDR_DATA);
    assign ctrl_wr   = bus_wr && (addr_i == ADDR_CTRL);
    assign flush_req = bus_wr && (addr_i == ADDR_FLUSH) && (write_data_i == 32'd1);

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == DEPTH_L);

    // The head is consumed during the LAUNCH cycle. A flush in that same
    // cycle wins, and an already-flushed FIFO has nothing to pop.
    assign pop_ok  = (state == S_LAUNCH) && !fifo_empty && !flush_req;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok = push_req && !flush_req && (!fifo_full || pop_ok);

    // Level saturates at 255 in the status field so DEPTH=256 still fits.
    assign level_wide  = 9'(level);
    assign level_field = level_wide[8] ? 8'hFF : level_wide[7:0];

    // Read mux for the registered read port.
    always_comb begin
        rd_mux = 32'd0;
        case (addr_i)
            ADDR_STATUS: rd_mux = {16'd0, level_field, 5'd0, ovf, fifo_full, fifo_empty};
            ADDR_CTRL:   rd_mux = {30'd0, ctrl_irq_en, ctrl_en};
            default:     rd_mux = 32'd0;
        endcase
    end

    // Control register: software-owned enable and interrupt enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en     <= write_data_i[0];
            ctrl_irq_en <= write_data_i[1];
        end
    end

    // FIFO storage has no reset; validity is tracked by the level counter.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= write_data_i[7:0];
        end
    end

    // Pointers, level counter and sticky overflow flag. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push_req && fifo_full && !pop_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WAIT_BUSY gives the core four cycles to raise busy;
    // if it never does (instant finish or dropped byte) the frame is treated
    // as done so the queue cannot stall.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_en && !fifo_empty && !tx_busy_i) begin
                    next_state = S_LAUNCH;
                    launch     = 1'b1;
                end
            end
            S_LAUNCH: begin
                next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    next_state = S_WAIT_DONE;
                end else if (wait_cnt == 2'd3) begin
                    next_state = S_GAP;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Timeout and inter-frame gap counters; both restart from zero every
    // time their state is entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= 2'd0;
            gap_cnt  <= 8'd0;
        end else begin
            wait_cnt <= (state == S_WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
            gap_cnt  <= (state == S_GAP && next_state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    // Registered outputs. tx_valid_o is high exactly while in LAUNCH, and the
    // head byte is captured on the same edge so it lines up with the strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_valid_o  <= 1'b0;
            tx_data_o   <= 8'd0;
            irq_o       <= 1'b0;
            read_data_o <= 32'd0;
        end else begin
            tx_valid_o  <= launch;
            if (launch) begin
                tx_data_o <= mem[rd_ptr];
            end
            irq_o       <= ctrl_irq_en && ctrl_en && fifo_empty &&
                           (state == S_IDLE) && !tx_busy_i;
            read_data_o <= bus_rd ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_sched
//
// Self-checking bench for uart_tx_fifo_sched. A behavioural uart_tx model
// raises busy for a fixed number of cycles per launched byte, or never raises
// it. Bytes expected on the wire are queued when pushed and compared in order
// whenever tx_valid_o is seen.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_sched;

    localparam int DEPTH    = 8;
    localparam int IDLE_GAP = 2;
    localparam int BUSY_CYC = 20;

    localparam logic [31:0] A_DATA   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_CTRL   = 32'h08;
    localparam logic [31:0] A_FLUSH  = 32'h0C;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        write_enable_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_busy_i;
    logic        irq_o;

    int          checks = 0;
    int          errors = 0;
    int          launches = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic        busy_never = 1'b0;
    logic        prev_valid = 1'b0;
    logic [7:0]  exp_b;
    logic [7:0]  exp_q[$];
    int          launch_times[$];

    uart_tx_fifo_sched #(
        .DEPTH    (DEPTH),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .write_enable_i (write_enable_i),
        .addr_i         (addr_i),
        .write_data_i   (write_data_i),
        .read_data_o    (read_data_o),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .tx_busy_i      (tx_busy_i),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // uart_tx model: busy for BUSY_CYC cycles after each accepted strobe.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_cnt <= 0;
        end else if (tx_valid_o && !busy_never) begin
            busy_cnt <= BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy_i = (busy_cnt != 0);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch monitor: one-cycle pulse width and in-order scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && tx_valid_o) begin
            checkOutput("pulse_width", {31'd0, prev_valid}, 32'd0);
            launches++;
            launch_times.push_back(cyc);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                checkOutput("tx_data", {24'd0, tx_data_o}, {24'd0, exp_b});
            end else begin
                checkOutput("spurious_launch", {31'd0, tx_valid_o}, 32'd0);
            end
        end
        prev_valid = rst_i ? 1'b0 : tx_valid_o;
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        req_i          = 1'b1;
        write_enable_i = we;
        addr_i         = addr;
        write_data_i   = data;
        @(posedge clk_i);
        #1;
        req_i          = 1'b0;
        write_enable_i = 1'b0;
        addr_i         = 32'd0;
        write_data_i   = 32'd0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, addr, 32'd0);
        data = read_data_o;
    endtask

    task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        readReg(addr, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic pushByte(input logic [7:0] b, input bit expect_tx);
        applyStimulus(1'b1, A_DATA, {24'd0, b});
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic waitLaunches(input string tag, input int target, input int budget);
        int n = 0;
        while (launches < target && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput(tag, launches, target);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!tx_valid_o && n < 10) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput(tag, {31'd0, tx_valid_o}, 32'd1);
    endtask

    // Hard stop in case a wait loop is ever broken.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t0;
        int sp;
        int n;

        rst_i          = 1'b1;
        req_i          = 1'b0;
        write_enable_i = 1'b0;
        addr_i         = 32'd0;
        write_data_i   = 32'd0;
        idle(3);

        // Reset values.
        checkOutput("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("rst_rdata", read_data_o, 32'd0);
        rst_i = 1'b0;
        idle(2);
        checkReg("status_reset", A_STATUS, 32'h1);
        checkReg("ctrl_reset", A_CTRL, 32'h0);
        idle(1);
        checkOutput("rdata_after_nonread", read_data_o, 32'd0);
        checkReg("unmapped_read", 32'h10, 32'h0);

        // Three bytes through a 20-cycle busy model.
        $display("[TB] basic three-byte message");
        applyStimulus(1'b1, A_CTRL, 32'h1);
        t0 = launch_times.size();
        pushByte(8'h41, 1'b1);
        pushByte(8'h42, 1'b1);
        pushByte(8'h43, 1'b1);
        waitLaunches("t1_launches", 3, 300);
        idle(BUSY_CYC + IDLE_GAP + 10);
        checkOutput("t1_exact_three", launches, 3);
        if (launch_times.size() >= t0 + 3) begin
            for (int i = 1; i < 3; i++) begin
                sp = launch_times[t0 + i] - launch_times[t0 + i - 1];
                checkOutput("t1_spacing",
                            {31'd0, (sp >= BUSY_CYC + IDLE_GAP + 2) && (sp <= BUSY_CYC + IDLE_GAP + 5)},
                            32'd1);
            end
        end
        checkReg("t1_status_end", A_STATUS, 32'h1);

        // Overflow with scheduler disabled, then flush.
        $display("[TB] overflow and flush");
        applyStimulus(1'b1, A_CTRL, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) pushByte(8'(8'h10 + i), 1'b0);
        checkReg("t2_status_ovf", A_STATUS, (32'(DEPTH) << 8) | 32'h6);
        applyStimulus(1'b1, A_FLUSH, 32'h2);
        checkReg("t2_flush_not1", A_STATUS, (32'(DEPTH) << 8) | 32'h6);
        applyStimulus(1'b1, A_FLUSH, 32'h1);
        checkReg("t2_status_flushed", A_STATUS, 32'h1);

        // Push into a full FIFO during the LAUNCH cycle.
        $display("[TB] push on launch while full");
        for (int i = 0; i < DEPTH; i++) pushByte(8'(8'hA0 + i), 1'b1);
        checkReg("t3_status_full", A_STATUS, (32'(DEPTH) << 8) | 32'h2);
        base = launches;
        applyStimulus(1'b1, A_CTRL, 32'h1);
        waitValid("t3_launch_seen");
        pushByte(8'h99, 1'b1);
        checkReg("t3_status_after", A_STATUS, (32'(DEPTH) << 8) | 32'h2);
        waitLaunches("t3_drain", base + DEPTH + 1, (DEPTH + 2) * 40);
        idle(40);
        checkReg("t3_status_end", A_STATUS, 32'h1);

        // Core that never raises busy.
        $display("[TB] busy never asserted");
        busy_never = 1'b1;
        base = launches;
        t0 = launch_times.size();
        pushByte(8'h51, 1'b1);
        pushByte(8'h52, 1'b1);
        pushByte(8'h53, 1'b1);
        waitLaunches("t4_launches", base + 3, 100);
        if (launch_times.size() >= t0 + 3) begin
            for (int i = 1; i < 3; i++) begin
                sp = launch_times[t0 + i] - launch_times[t0 + i - 1];
                checkOutput("t4_spacing", {31'd0, (sp >= 5) && (sp <= 12)}, 32'd1);
            end
        end
        idle(20);
        checkReg("t4_status_end", A_STATUS, 32'h1);
        busy_never = 1'b0;

        // Disable mid-frame with bytes queued, then resume.
        $display("[TB] disable mid-frame");
        applyStimulus(1'b1, A_CTRL, 32'h0);
        for (int i = 0; i < 6; i++) pushByte(8'(8'h60 + i), 1'b1);
        base = launches;
        applyStimulus(1'b1, A_CTRL, 32'h1);
        n = 0;
        while (!tx_busy_i && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput("t5_busy_seen", {31'd0, tx_busy_i}, 32'd1);
        applyStimulus(1'b1, A_CTRL, 32'h0);
        idle(80);
        checkOutput("t5_no_new_launch", launches, base + 1);
        checkReg("t5_status_level5", A_STATUS, 32'h500);
        applyStimulus(1'b1, A_CTRL, 32'h1);
        waitLaunches("t5_resume", base + 6, 300);
        idle(40);
        checkReg("t5_status_end", A_STATUS, 32'h1);

        // Asynchronous reset in the middle of a launch.
        $display("[TB] async reset during launch");
        applyStimulus(1'b1, A_CTRL, 32'h3);
        pushByte(8'h77, 1'b0);
        checkReg("t6_status_launch", A_STATUS, 32'h100);
        checkOutput("t6_in_launch", {31'd0, tx_valid_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("t6_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        checkOutput("t6_rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("t6_rst_rdata", read_data_o, 32'd0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        exp_q.delete();
        idle(2);
        checkReg("t6_status_after", A_STATUS, 32'h1);
        checkReg("t6_ctrl_after", A_CTRL, 32'h0);

        // Interrupt behaviour around one byte.
        $display("[TB] interrupt");
        base = launches;
        applyStimulus(1'b1, A_CTRL, 32'h3);
        idle(2);
        checkOutput("t7_irq_idle", {31'd0, irq_o}, 32'd1);
        pushByte(8'h88, 1'b1);
        idle(1);
        checkOutput("t7_irq_pending", {31'd0, irq_o}, 32'd0);
        idle(10);
        checkOutput("t7_irq_busy", {31'd0, irq_o}, 32'd0);
        n = 0;
        while (!irq_o && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput("t7_irq_drained", {31'd0, irq_o}, 32'd1);
        checkReg("t7_ctrl", A_CTRL, 32'h3);
        pushByte(8'h89, 1'b1);
        idle(1);
        checkOutput("t7_irq_push", {31'd0, irq_o}, 32'd0);
        waitLaunches("t7_launches", base + 2, 100);
        idle(40);
        checkReg("t7_status_end", A_STATUS, 32'h1);
        checkOutput("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
